if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch control stage that sits between the PC register and the IF/ID boundary. It reads pc_current, issues one instruction-memory request at a time over a req/gnt/rvalid handshake, and drives pc_next and pc_en back into the PC register. It also owns the IF/ID output register (valid, pc, instr) with stall and redirect/flush support. A one-entry skid buffer absorbs a response that arrives while ID is stalled.

Parameters:
XLEN, 32, address/data width
PC_INC, 4, sequential PC increment
NOP_INSTR, 32'h00000013, instruction value presented when invalid or in reset (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_current  input  XLEN  current PC from PC register
pc_next  output  XLEN  next PC to PC register (combinational)
pc_en  output  1  PC register enable (combinational)
imem_req  output  1  fetch request valid
imem_addr  output  XLEN  fetch address (= pc_current)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response valid; in order; at most one outstanding
imem_rdata  input  XLEN  fetched instruction
stall  input  1  ID not accepting; IF/ID register holds
redirect  input  1  branch/jump taken; flush and refetch
redirect_pc  input  XLEN  redirect target
ifid_valid  output  1  IF/ID entry valid
ifid_pc  output  XLEN  PC of IF/ID instruction
ifid_instr  output  XLEN  IF/ID instruction

Behaviour:
- States: IDLE, REQ, WAIT, HOLD, DROP. Reset: state=IDLE, ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR, skid buffer empty, fetch_pc=0. While rst_n=0: imem_req=0, pc_en=0.
- IDLE: one cycle after reset release, then REQ. No request is issued.
- imem_req = (state==REQ) && !redirect. imem_addr = pc_current.
- REQ: on imem_req && imem_gnt, capture fetch_pc<=pc_current, assert pc_en, set pc_next=pc_current+PC_INC (mod 2^XLEN, wraps 0xFFFFFFFC->0), and go to WAIT. Without gnt, hold imem_addr and keep pc_en=0.
- out_ready = !ifid_valid || !stall.
- WAIT: on imem_rvalid:
  - If out_ready: ifid_valid<=1, ifid_pc<=fetch_pc, ifid_instr<=imem_rdata, go to REQ.
  - Otherwise: load the skid buffer (pc, instr) and go to HOLD.
- HOLD: no request is issued. When out_ready, move the buffer into IF/ID and go to REQ.
- DROP: a stale request is outstanding. imem_req=0. On imem_rvalid, discard the data and go to REQ.
- imem_rvalid is ignored in IDLE, REQ and HOLD.
- IF/ID register:
  - If !stall and no new entry is loaded this cycle, ifid_valid<=0 (entry consumed).
  - If stall, all ifid_* hold.
  - ifid_instr and ifid_pc update only on load.
- Redirect has highest priority, regardless of stall:
  - pc_en=1, pc_next=redirect_pc.
  - ifid_valid<=0 and the skid buffer is cleared.
  - State transitions:
    - REQ -> REQ (no request issued that cycle).
    - WAIT without rvalid -> DROP.
    - WAIT with rvalid in the same cycle -> data discarded, go to REQ.
    - HOLD -> REQ.
    - DROP -> DROP.
    - IDLE -> REQ.
- Latency: 1 cycle from gnt to earliest rvalid. IF/ID is visible the cycle after rvalid. Peak throughput is one instruction per 2 cycles.
- Asynchronous reset at any point returns to the reset values immediately. Any in-flight response after reset is ignored, because rvalid is not sampled in IDLE or REQ.

Test Plan:
1. Reset, then gnt=1 always and rvalid one cycle after each gnt, with memory word = address. Expected: ifid_pc/ifid_instr sequence 0x0, 0x4, 0x8, one new entry every 2 cycles, and pc_en pulses once per grant.
2. gnt held low 3 cycles in REQ with pc_current=0x20. Expected: imem_req=1 and imem_addr=0x20 stable, pc_en=0; on gnt, pc_en=1 and pc_next=0x24.
3. ifid_valid=1 and stall=1 when rvalid returns instr 0xABCD0013 for pc 0x8. Expected: HOLD, IF/ID unchanged, no request. Drop stall: ifid_pc=0x8, ifid_instr=0xABCD0013 next cycle, then REQ.
4. redirect=1 with redirect_pc=0x100 in WAIT, rvalid 2 cycles later. Expected: ifid_valid=0, pc_next=0x100 with pc_en=1, late response discarded, next imem_addr=0x100.
5. redirect coincident with rvalid, and separately coincident with gnt. Expected: rvalid case, data discarded and IF/ID stays invalid; gnt case, imem_req=0 that cycle and the next request goes to redirect_pc.
6. pc_current=0xFFFFFFFC granted. Expected: pc_next=0x0. Assert rst_n=0 mid-WAIT, then rvalid after release. Expected: outputs at reset values, response ignored, first request after IDLE.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch control between the PC register and IF/ID.
// Issues one imem request at a time (req/gnt/rvalid, at most one outstanding),
// steers the PC register via pc_next/pc_en, and owns the IF/ID register with
// stall, redirect/flush and a one-entry skid buffer for responses that arrive
// while ID is stalled.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   pc_current                  current PC from the PC register
//   pc_next, pc_en              next PC and load enable to the PC register (comb)
//   imem_req, imem_addr         fetch request and address (comb)
//   imem_gnt                    request accepted this cycle
//   imem_rvalid, imem_rdata     in-order fetch response
//   stall                       ID not accepting; IF/ID holds
//   redirect, redirect_pc       taken branch/jump: flush and refetch at target
//   ifid_valid/pc/instr         IF/ID output register
module if_fetch_unit #(
    parameter int unsigned       XLEN      = 32,
    parameter int unsigned       PC_INC    = 4,
    parameter logic [XLEN-1:0]   NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_current,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_en,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_instr
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;

    logic            out_ready;
    logic            load_new;
    logic            load_skid;

    assign imem_addr  = pc_current;
    assign ifid_valid = ifid_valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;

    // State, PC control, skid buffer and IF/ID next values.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        imem_req     = 1'b0;
        pc_en        = 1'b0;
        pc_next      = pc_current + XLEN'(PC_INC);
        load_new     = 1'b0;
        load_skid    = 1'b0;
        out_ready    = !ifid_valid_q || !stall;

        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                imem_req = !redirect;
                if (!redirect && imem_gnt) begin
                    pc_en      = 1'b1;
                    fetch_pc_d = pc_current;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // A response landing with the redirect retires the request.
                    state_d = imem_rvalid ? REQ : DROP;
                end else if (imem_rvalid) begin
                    if (out_ready) begin
                        load_new = 1'b1;
                        state_d  = REQ;
                    end else begin
                        skid_pc_d    = fetch_pc_q;
                        skid_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = REQ;
                end else if (out_ready) begin
                    load_skid = 1'b1;
                    state_d   = REQ;
                end
            end
            DROP: begin
                // Stale response retires the request even under a new redirect,
                // otherwise nothing would ever leave DROP.
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            pc_en        = 1'b1;
            pc_next      = redirect_pc;
            ifid_valid_d = 1'b0;
            skid_pc_d    = '0;
            skid_instr_d = NOP_INSTR;
        end else if (load_new) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = fetch_pc_q;
            ifid_instr_d = imem_rdata;
        end else if (load_skid) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = skid_pc_q;
            ifid_instr_d = skid_instr_q;
        end else if (!stall) begin
            ifid_valid_d = 1'b0;
        end

        // PC register and memory must see nothing while reset is asserted.
        if (!rst_n) begin
            imem_req = 1'b0;
            pc_en    = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_pc_q   <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. The PC register is played by the stimulus:
// pc_current is written by hand each cycle with the value it would hold.
module tb_if_fetch_unit;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] pc_current;
    logic [XLEN-1:0] pc_next;
    logic            pc_en;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            ifid_valid;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] ifid_instr;

    int n_chk  = 0;
    int n_fail = 0;

    if_fetch_unit #(.XLEN(XLEN), .PC_INC(4), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_current  (pc_current),
        .pc_next     (pc_next),
        .pc_en       (pc_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_instr  (ifid_instr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are set here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before checking.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        pc_current  = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        stall       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;

        // ---- Reset values (redirect held high to show pc_en is gated) ----
        tick(); settle();
        chk("rst_ifid_valid", 32'(ifid_valid), 32'd0);
        chk("rst_ifid_pc",    ifid_pc,         32'h0);
        chk("rst_ifid_instr", ifid_instr,      NOP);
        chk("rst_imem_req",   32'(imem_req),   32'd0);
        chk("rst_pc_en",      32'(pc_en),      32'd0);
        redirect = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        chk("idle_no_req", 32'(imem_req), 32'd0);

        // ---- 1: streaming fetch, gnt always, rvalid one cycle after gnt ----
        tick();
        for (int k = 0; k < 3; k++) begin
            imem_gnt    = 1'b1;
            imem_rvalid = 1'b0;
            settle();
            chk("seq_req",     32'(imem_req), 32'd1);
            chk("seq_addr",    imem_addr,     32'(4 * k));
            chk("seq_pc_en",   32'(pc_en),    32'd1);
            chk("seq_pc_next", pc_next,       32'(4 * k + 4));
            if (k > 0) begin
                chk("seq_ifid_valid", 32'(ifid_valid), 32'd1);
                chk("seq_ifid_pc",    ifid_pc,         32'(4 * (k - 1)));
                chk("seq_ifid_instr", ifid_instr,      32'(4 * (k - 1)));
            end
            tick();
            pc_current  = 32'(4 * k + 4);
            imem_rvalid = 1'b1;
            imem_rdata  = 32'(4 * k);
            settle();
            chk("seq_wait_noreq",  32'(imem_req),   32'd0);
            chk("seq_wait_pc_en",  32'(pc_en),      32'd0);
            chk("seq_consumed",    32'(ifid_valid), 32'd0);
            tick();
        end
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        settle();
        chk("seq_last_valid", 32'(ifid_valid), 32'd1);
        chk("seq_last_pc",    ifid_pc,         32'h8);
        chk("seq_last_instr", ifid_instr,      32'h8);

        // ---- 2: gnt withheld three cycles at 0x20 ----
        pc_current = 32'h20;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("nognt_req",   32'(imem_req), 32'd1);
            chk("nognt_addr",  imem_addr,     32'h20);
            chk("nognt_pc_en", 32'(pc_en),    32'd0);
            tick();
        end
        imem_gnt = 1'b1;
        settle();
        chk("gnt_pc_en",   32'(pc_en), 32'd1);
        chk("gnt_pc_next", pc_next,    32'h24);
        tick();
        imem_gnt    = 1'b0;
        pc_current  = 32'h24;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h20;
        tick();

        // ---- 3: response while IF/ID valid and stalled goes to the skid ----
        imem_rvalid = 1'b0;
        stall       = 1'b1;
        pc_current  = 32'h8;
        imem_gnt    = 1'b1;
        settle();
        chk("stall_ifid_pc", ifid_pc, 32'h20);
        tick();
        imem_gnt    = 1'b0;
        pc_current  = 32'hC;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hABCD_0013;
        tick();
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b1;
        settle();
        chk("hold_noreq",      32'(imem_req),   32'd0);
        chk("hold_ifid_valid", 32'(ifid_valid), 32'd1);
        chk("hold_ifid_pc",    ifid_pc,         32'h20);
        chk("hold_ifid_instr", ifid_instr,      32'h20);
        tick();
        settle();
        chk("hold2_noreq",   32'(imem_req), 32'd0);
        chk("hold2_ifid_pc", ifid_pc,       32'h20);
        stall    = 1'b0;
        imem_gnt = 1'b0;
        tick();
        settle();
        chk("skid_ifid_valid", 32'(ifid_valid), 32'd1);
        chk("skid_ifid_pc",    ifid_pc,         32'h8);
        chk("skid_ifid_instr", ifid_instr,      32'hABCD_0013);
        chk("skid_then_req",   32'(imem_req),   32'd1);

        // ---- 4: redirect in WAIT (under stall), late response dropped ----
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        pc_current  = 32'h10;
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        settle();
        chk("redir_pc_en",   32'(pc_en), 32'd1);
        chk("redir_pc_next", pc_next,    32'h100);
        tick();
        redirect   = 1'b0;
        stall      = 1'b0;
        pc_current = 32'h100;
        settle();
        chk("redir_flush",      32'(ifid_valid), 32'd0);
        chk("drop_noreq",       32'(imem_req),   32'd0);
        tick();
        settle();
        chk("drop_noreq2",      32'(imem_req),   32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        settle();
        chk("drop_discard",     32'(ifid_valid), 32'd0);
        chk("drop_then_req",    32'(imem_req),   32'd1);
        chk("drop_then_addr",   imem_addr,       32'h100);

        // ---- 5a: redirect coincident with rvalid ----
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        pc_current  = 32'h104;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h55;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        settle();
        chk("rv_redir_pc_next", pc_next, 32'h200);
        tick();
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        pc_current  = 32'h200;
        settle();
        chk("rv_redir_invalid", 32'(ifid_valid), 32'd0);
        chk("rv_redir_req",     32'(imem_req),   32'd1);
        chk("rv_redir_addr",    imem_addr,       32'h200);

        // ---- 5b: redirect coincident with gnt ----
        imem_gnt    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        settle();
        chk("gnt_redir_noreq",   32'(imem_req), 32'd0);
        chk("gnt_redir_pc_en",   32'(pc_en),    32'd1);
        chk("gnt_redir_pc_next", pc_next,       32'h300);
        tick();
        redirect   = 1'b0;
        pc_current = 32'h300;
        settle();
        chk("gnt_redir_req",     32'(imem_req), 32'd1);
        chk("gnt_redir_addr",    imem_addr,     32'h300);
        chk("gnt_redir_pc_next2", pc_next,      32'h304);
        tick();
        imem_gnt    = 1'b0;
        pc_current  = 32'h304;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0030_0013;
        tick();
        imem_rvalid = 1'b0;
        stall       = 1'b1;
        settle();
        chk("gnt_redir_ifid_pc",    ifid_pc,    32'h300);
        chk("gnt_redir_ifid_instr", ifid_instr, 32'h0030_0013);

        // ---- 6: PC wrap, then async reset mid-WAIT with a late response ----
        pc_current = 32'hFFFF_FFFC;
        imem_gnt   = 1'b1;
        settle();
        chk("wrap_pc_en",   32'(pc_en), 32'd1);
        chk("wrap_pc_next", pc_next,    32'h0);
        tick();
        imem_gnt   = 1'b0;
        pc_current = 32'h0;
        stall      = 1'b0;
        rst_n      = 1'b0;
        settle();
        chk("arst_ifid_valid", 32'(ifid_valid), 32'd0);
        chk("arst_ifid_pc",    ifid_pc,         32'h0);
        chk("arst_ifid_instr", ifid_instr,      NOP);
        chk("arst_req",        32'(imem_req),   32'd0);
        chk("arst_pc_en",      32'(pc_en),      32'd0);
        tick();
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h77;
        settle();
        chk("arst_idle_noreq", 32'(imem_req), 32'd0);
        tick();
        settle();
        chk("arst_ignored",  32'(ifid_valid), 32'd0);
        chk("arst_req_addr", imem_addr,       32'h0);
        chk("arst_first_req", 32'(imem_req),  32'd1);
        tick();
        imem_rvalid = 1'b0;
        settle();
        chk("arst_still_invalid", 32'(ifid_valid), 32'd0);
        chk("arst_instr_nop",     ifid_instr,      NOP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
